fe_freeze_pack: RTL and testbench

- Downstream consumer of the field multiplier's 5x51-bit limb result; accepts one weakly-reduced element of GF(2^255-19).
- Performs a constant-time final reduction to the canonical value in [0, p), where p = 2^255-19.
- Packs the canonical value into 256 bits, little-endian, and streams it out as WORD_W-bit words under a valid/ready handshake.
- Sits between the arithmetic core and the byte/bus interface of the gate.

---
 rtl/fe_freeze_pack.sv | 81 ++++++++
 tb/tb_fe_freeze_pack.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fe_freeze_pack.sv
// fe_freeze_pack: reduces a 5x51-bit GF(2^255-19) element to canonical form in constant time and streams it as little-endian WORD_W words (in_valid/in_ready/in_limbs accept, out_valid/out_ready/out_data/out_idx/out_last emit)
module fe_freeze_pack #(
  parameter int WORD_W = 32,
  localparam int NWORDS = 256 / WORD_W,
  localparam int IW = $clog2(NWORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [319:0]      in_limbs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [IW-1:0]     out_idx,
  output logic              out_last
);
  typedef enum logic [1:0] {IDLE, PROBE, SUB, EMIT} state_t;
  state_t state_q, state_d;
  logic [4:0][50:0] x_q, x_d;
  logic q_q, q_d;
  logic [255:0] pack_q, pack_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [52:0] t [5];
  logic [52:0] s [5];
  logic unused_bits;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    q_d = q_q;
    pack_d = pack_q;
    idx_d = idx_q;
    t[0] = {2'b0, x_q[0]} + 53'd19;
    s[0] = {2'b0, x_q[0]} + (53'd19 & {53{q_q}});
    for (int k = 1; k < 5; k++) begin
      t[k] = {2'b0, x_q[k]} + {52'd0, t[k-1][51]};
      s[k] = {2'b0, x_q[k]} + {52'd0, s[k-1][51]};
    end
    unused_bits = 1'b0;
    for (int k = 0; k < 5; k++) unused_bits = unused_bits ^ (^t[k]) ^ (^s[k]) ^ (^in_limbs[64*k+51 +: 13]);
    case (state_q)
      IDLE: if (in_valid) begin
        for (int k = 0; k < 5; k++) x_d[k] = in_limbs[64*k +: 51];
        state_d = PROBE;
      end
      PROBE: begin
        q_d = t[4][51];
        state_d = SUB;
      end
      SUB: begin
        pack_d = {1'b0, s[4][50:0], s[3][50:0], s[2][50:0], s[1][50:0], s[0][50:0]};
        idx_d = '0;
        state_d = EMIT;
      end
      default: if (out_ready) begin
        idx_d = idx_q + IW'(1);
        state_d = idx_q == IW'(NWORDS - 1) ? IDLE : EMIT;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      q_q <= 1'b0;
      pack_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      q_q <= q_d;
      pack_q <= pack_d;
      idx_q <= idx_d;
    end
  end
  assign in_ready = rst_n && state_q == IDLE;
  assign out_valid = state_q == EMIT;
  assign out_data = pack_q[WORD_W*idx_q +: WORD_W];
  assign out_idx = idx_q;
  assign out_last = out_valid && idx_q == IW'(NWORDS - 1);
endmodule

// File: tb/tb_fe_freeze_pack.sv
// tb_fe_freeze_pack: randomized scoreboard bench for fe_freeze_pack (32-bit and 8-bit word builds)
module tb_fe_freeze_pack;
  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;
  typedef struct packed {logic [63:0] d; logic [7:0] i; logic l;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [319:0] in_limbs = '0, rl;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last;
  logic [31:0] out_data;
  logic [2:0] out_idx;
  logic in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, out_last8;
  logic [7:0] out_data8;
  logic [4:0] out_idx8;
  exp_t sb[$], sb8[$];
  int checks = 0, errors = 0, g;
  bit chk_rdy = 0, chk_rdy8 = 0;
  fe_freeze_pack #(.WORD_W(32)) dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_limbs(in_limbs), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last));
  fe_freeze_pack #(.WORD_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_limbs(in_limbs), .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_idx(out_idx8), .out_last(out_last8));
  function automatic logic [255:0] canon(input logic [319:0] l);
    logic [255:0] x = '0;
    for (int k = 0; k < 5; k++) x = x + (256'(l[64*k +: 51]) << (51 * k));
    return (x >= P) ? x - P : x;
  endfunction
  function automatic logic [319:0] mk(input logic [63:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [255:0] v, input int w);
    exp_t e;
    logic [63:0] m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    for (int k = 0; k < 256 / w; k++) begin
      e.d = 64'(v >> (w * k)) & m;
      e.i = 8'(k);
      e.l = (k == 256 / w - 1);
      if (w == 8) sb8.push_back(e);
      else sb.push_back(e);
    end
  endtask
  always @(negedge clk) begin
    if (chk_rdy) begin
      chk_rdy = 0;
      check("in_ready_after_last", 64'(in_ready), 64'(1));
    end
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got idx=%0d data=%0h expected no output", out_idx, out_data);
      end else begin
        check("word_data", 64'(out_data), sb[0].d);
        check("word_idx", 64'(out_idx), 64'(sb[0].i));
        check("word_last", 64'(out_last), 64'(sb[0].l));
        if (out_ready) begin
          chk_rdy = sb[0].l;
          void'(sb.pop_front());
        end
      end
    end
  end
  always @(negedge clk) begin
    if (chk_rdy8) begin
      chk_rdy8 = 0;
      check("in_ready8_after_last", 64'(in_ready8), 64'(1));
    end
    if (out_valid8) begin
      if (sb8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got idx=%0d data=%0h expected no output", out_idx8, out_data8);
      end else begin
        check("byte_data", 64'(out_data8), sb8[0].d);
        check("byte_idx", 64'(out_idx8), 64'(sb8[0].i));
        check("byte_last", 64'(out_last8), 64'(sb8[0].l));
        if (out_ready8) begin
          chk_rdy8 = sb8[0].l;
          void'(sb8.pop_front());
        end
      end
    end
  end
  // mode 0: out_ready always high; 1: random out_ready; 2: stall 5 cycles at word 3 while pulsing in_valid
  task automatic send(input logic [319:0] l, input int mode);
    int w = 0, n = 0, st = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
      return;
    end
    in_limbs = l;
    in_valid = 1'b1;
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    push(canon(l), 32);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 10; k++) in_limbs[32*k +: 32] = $urandom();
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    check("first_valid_latency", 64'(n), 64'(3));
    w = 0;
    while (sb.size() != 0 && w < 400) begin
      @(posedge clk);
      #1 w++;
      if (mode == 2 && out_valid && out_idx == 3'd3 && st < 5) begin
        out_ready = 1'b0;
        in_valid = 1'b1;
        st++;
        check("in_ready_during_emit", 64'(in_ready), 64'(0));
      end else begin
        in_valid = 1'b0;
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    in_valid = 1'b0;
    if (mode == 0) check("stream_cycles", 64'(w), 64'(8));
    if (mode == 2) check("stall_cycles", 64'(st), 64'(5));
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got %0d words left expected 0", sb.size());
      sb.delete();
    end
    out_ready = 1'b1;
  endtask
  task automatic send8(input logic [319:0] l);
    int w = 0;
    @(negedge clk);
    while (!in_ready8 && w < 100) begin @(negedge clk); w++; end
    in_limbs = l;
    in_valid8 = 1'b1;
    push(canon(l), 8);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    w = 0;
    while (sb8.size() != 0 && w < 100) begin @(posedge clk); #1 w++; end
    check("stream8_cycles", 64'(w), 64'(34));
    sb8.delete();
  endtask
  initial begin
    #12;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_idx", 64'(out_idx), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_out_valid8", 64'(out_valid8), 64'(0));
    #5 rst_n = 1'b1;
    send('0, 0);
    send(mk(64'h7FFFFFFFFFFED, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF), 0);
    send(mk(64'h7FFFFFFFFFFEE, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF), 0);
    send(mk(64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF), 0);
    send(mk(64'h7FFFFFFFFFFEC, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF), 0);
    send(mk(64'h7FFFFFFFFFFEC, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF), 2);
    send(mk(64'hFFF8000000000001, 64'h0, 64'h0, 64'h0, 64'h0), 0);
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 10; k++) rl[32*k +: 32] = $urandom();
      if (r % 2 == 1) begin
        for (int k = 1; k < 5; k++) rl[64*k +: 51] = '1;
        rl[50:0] = 51'h7FFFFFFFFFFE0 + 51'($urandom_range(0, 31));
      end
      send(rl, 1);
    end
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    in_limbs = '0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    push('0, 32);
    @(posedge clk);
    #1 in_valid = 1'b0;
    g = 0;
    while (!(out_valid && out_idx == 3'd2) && g < 20) begin @(posedge clk); #1 g++; end
    check("reached_idx2", 64'(out_idx), 64'(2));
    #1 rst_n = 1'b0;
    #1 check("async_rst_out_valid", 64'(out_valid), 64'(0));
    check("async_rst_in_ready", 64'(in_ready), 64'(0));
    check("async_rst_out_idx", 64'(out_idx), 64'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    check("post_rst_out_data", 64'(out_data), 64'(0));
    send('0, 0);
    send8(mk(64'h7FFFFFFFFFFEC, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF, 64'h7FFFFFFFFFFFF));
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 10; k++) rl[32*k +: 32] = $urandom();
      send8(rl);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
